// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: restartable sweep of x = 0..7 into a 3-input logic block,
// checking z against TRUTH_TABLE and keeping mismatch count, map and first index.
module tt_sweep_checker #(
    parameter logic [7:0]  TRUTH_TABLE = 8'b0000_0000,
    parameter int unsigned SETTLE      = 2
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       start,
    input  logic       z,
    output logic [2:0] x,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       err,
    output logic [3:0] err_count,
    output logic [7:0] mismatch_map,
    output logic [2:0] first_err_idx
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DONE} state_e;
    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

    state_e     state_q, state_d;
    logic [2:0] x_q, x_d;
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic [3:0] ecnt_q, ecnt_d;
    logic [7:0] map_q, map_d;
    logic [2:0] first_q, first_d;
    logic       mis;

    // X or Z on z must count as a mismatch, hence the case inequality
    assign mis = (z !== TRUTH_TABLE[x_q]);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        ecnt_d  = ecnt_q;
        map_d   = map_q;
        first_d = first_q;
        if (state_q != S_SETTLE) begin
            if (start) begin
                state_d = S_SETTLE;
                x_d     = 3'd0;
                cnt_d   = RELOAD;
                ecnt_d  = 4'd0;
                map_d   = 8'd0;
                first_d = 3'd0;
            end
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            if (mis) begin
                err_d        = 1'b1;
                ecnt_d       = ecnt_q + 4'd1;
                map_d[x_q]   = 1'b1;
                first_d      = (ecnt_q == 4'd0) ? x_q : first_q;
            end
            if (x_q == 3'd7) begin
                state_d = S_DONE;
            end else begin
                x_d   = x_q + 3'd1;
                cnt_d = RELOAD;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= 3'd0;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            ecnt_q  <= 4'd0;
            map_q   <= 8'd0;
            first_q <= 3'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ecnt_q  <= ecnt_d;
            map_q   <= map_d;
            first_q <= first_d;
        end
    end

    assign x             = x_q;
    assign busy          = (state_q == S_SETTLE);
    assign done          = (state_q == S_DONE);
    assign pass          = (state_q == S_DONE) && (ecnt_q == 4'd0);
    assign err           = err_q;
    assign err_count     = ecnt_q;
    assign mismatch_map  = map_q;
    assign first_err_idx = first_q;
endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb_tt_sweep_checker: three checker instances (SETTLE 2/1/3) against a behavioural
// logic model; expected sweep results are queued at start and checked as the sweep runs.
module tb_tt_sweep_checker;
    localparam logic [7:0] PAR = 8'b1001_0110;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [2:0] start = '0;
    logic [2:0] z, busy, done, pass, err;
    logic [2:0][2:0] x, fidx;
    logic [2:0][3:0] ecnt;
    logic [2:0][7:0] map;
    logic [2:0][7:0] base, flip, xm;
    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int         u;
        int         k;
        logic [7:0] mis;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign z[g] = xm[g][x[g]] ? 1'bx : (base[g][x[g]] ^ flip[g][x[g]]);
        tt_sweep_checker #(
            .TRUTH_TABLE(g == 1 ? 8'hFF : PAR),
            .SETTLE(g == 0 ? 2 : (g == 1 ? 1 : 3))
        ) u_dut (
            .clock(clk), .rst_n(rst_n), .start(start[g]), .z(z[g]), .x(x[g]),
            .busy(busy[g]), .done(done[g]), .pass(pass[g]), .err(err[g]),
            .err_count(ecnt[g]), .mismatch_map(map[g]), .first_err_idx(fidx[g])
        );
    end

    function automatic int settle_of(int u);
        return u == 0 ? 2 : (u == 1 ? 1 : 3);
    endfunction

    function automatic logic [7:0] exp_mis(int u);
        logic [7:0] tt, m;
        tt = (u == 1) ? 8'hFF : PAR;
        for (int i = 0; i < 8; i++)
            m[i] = xm[u][i] | ((base[u][i] ^ flip[u][i]) != tt[i]);
        return m;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic push(int u);
        sb.push_back(exp_t'{u: u, k: cyc, mis: exp_mis(u)});
    endtask

    task automatic pulse(int u);
        @(negedge clk);
        start[u] = 1'b1;
        @(posedge clk);
        #1;
        push(u);
        start[u] = 1'b0;
    endtask

    task automatic drain(int lim);
        int n = 0;
        while (sb.size() > 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic wait_done(int u);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[u] && n < 200);
        chk("wait_done", 32'(done[u]), 32'd1);
    endtask

    task automatic rst_chk(string tag);
        chk({tag, "_x"}, 32'(x), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_cnt"}, 32'(ecnt), 32'd0);
        chk({tag, "_map"}, 32'(map), 32'd0);
        chk({tag, "_fidx"}, 32'(fidx), 32'd0);
    endtask

    // Time-based model of the current sweep: x, busy, done and err per cycle
    always @(negedge clk) begin : mon
        exp_t e;
        int   s, d, u, fi;
        if (rst_n && sb.size() > 0) begin
            e = sb[0];
            u = e.u;
            s = settle_of(u);
            d = cyc - e.k;
            if (d >= 0 && d <= 8 * s) begin
                chk("x", 32'(x[u]), (d == 8 * s) ? 32'd7 : 32'(d / s));
                chk("busy", 32'(busy[u]), 32'(d < 8 * s));
                chk("done", 32'(done[u]), 32'(d == 8 * s));
                chk("err", 32'(err[u]), (d > 0 && d % s == 0) ? 32'(e.mis[d / s - 1]) : 32'd0);
            end
            if (d >= 8 * s) begin
                fi = 0;
                for (int i = 7; i >= 0; i--) if (e.mis[i]) fi = i;
                chk("err_count", 32'(ecnt[u]), 32'($countones(e.mis)));
                chk("mismatch_map", 32'(map[u]), 32'(e.mis));
                if (e.mis != 8'd0) chk("first_err_idx", 32'(fidx[u]), 32'(fi));
                chk("pass", 32'(pass[u]), 32'(e.mis == 8'd0));
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        int k0, n;
        base = {PAR, 8'hFF, PAR};
        flip = '0;
        xm   = '0;
        #1 rst_n = 1'b0;
        #1 rst_chk("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        pulse(0);
        drain(100);

        flip[0] = 8'b0100_1000;
        pulse(0);
        drain(100);
        @(negedge clk);
        chk("hold_done", 32'(done[0]), 32'd1);
        chk("hold_pass", 32'(pass[0]), 32'd0);
        chk("hold_cnt", 32'(ecnt[0]), 32'd2);
        flip[0] = 8'd0;
        pulse(0);
        chk("restart_done", 32'(done[0]), 32'd0);
        chk("restart_cnt", 32'(ecnt[0]), 32'd0);
        chk("restart_map", 32'(map[0]), 32'd0);
        drain(100);

        xm[1] = 8'h01;
        pulse(1);
        drain(100);
        xm[1] = 8'h00;

        pulse(0);
        repeat (5) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        drain(100);

        pulse(0);
        n = 0;
        while (x[0] != 3'd4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_x", 32'(x[0]), 32'd4);
        #2 rst_n = 1'b0;
        #1 rst_chk("async_rst");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        pulse(0);
        drain(100);

        @(negedge clk);
        start[2] = 1'b1;
        @(posedge clk);
        #1;
        k0 = cyc;
        push(2);
        for (int s = 0; s < 3; s++) begin
            wait_done(2);
            chk("cont_edge", 32'(cyc - k0), 32'(24 + 25 * s));
            if (s < 2) begin
                @(posedge clk);
                #1;
                push(2);
            end
        end
        start[2] = 1'b0;
        drain(100);
        @(negedge clk);
        chk("cont_stop_busy", 32'(busy[2]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/tt_sweep_checker.md
# tt_sweep_checker

Clocked stimulus-and-check stage for the 3-input combinational logic labs. On `start` it drives every input vector `x[2:0]` = 0..7 into the logic under test and waits a programmable settle interval for each. It compares the returned `z` against the `TRUTH_TABLE` parameter and accumulates a mismatch count, a per-vector mismatch map and the first failing index. It sits directly upstream of the logic under test, which consumes `x`, and directly downstream of it, consuming `z`. It replaces the free-running stimulus loop with a synthesizable, restartable sequencer.

## Interface
Parameters:
- `TRUTH_TABLE`, default 8'b0000_0000: bit i is the expected `z` for `x == i`.
- `SETTLE`, default 2: clock cycles each vector is held before `z` is sampled; legal range 1..15.

Ports:
- `clock`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  sweep request, sampled only in IDLE or DONE.
- `z`  in  1  output of the logic under test.
- `x`  out  3  vector driven to the logic under test (`x[0]` is the LSB).
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep complete; results valid.
- `pass`  out  1  done and zero mismatches.
- `err`  out  1  one-cycle strobe on a mismatching sample.
- `err_count`  out  4  number of mismatching vectors, 0..8.
- `mismatch_map`  out  8  bit i set if vector i mismatched.
- `first_err_idx`  out  3  index of the first mismatching vector; meaningful only when `err_count != 0`.

## Operation
- State machine states are IDLE, SETTLE and DONE. State and all outputs are registered.
- **IDLE.** Entered from reset.
  - On `start = 1`: x ← 0; settle counter ← SETTLE-1; clear `err_count`, `mismatch_map` and `first_err_idx`; next state is SETTLE.
- **SETTLE.** `busy = 1`; `start` is ignored.
  - Counter ≠ 0: decrement the counter.
  - Counter = 0 (sample cycle): compare `z` against `TRUTH_TABLE[x]`.
    - The comparison is 4-state: X or Z on `z` counts as a mismatch.
    - On mismatch: `err` ← 1 for one cycle; `err_count` += 1; `mismatch_map[x]` ← 1.
    - If this is the first mismatch of the sweep, `first_err_idx` ← x.
    - If x = 7: next state is DONE and `x` holds at 7.
    - Otherwise: x ← x + 1 and reload the counter with SETTLE-1.
- **DONE.**
  - `done = 1` and `pass = (err_count == 0)`; result registers hold.
  - `start = 1` restarts the sweep exactly as from IDLE. There is no one-cycle gap, and `done` and `pass` drop on the same edge.
- `err_count` cannot overflow: there are at most 8 increments and the width is 4 bits.
- `x` never wraps past 7 within a sweep. The sweep always ends at x = 7.

## Timing
- Reset values, applied immediately on `rst_n` low (asynchronous):
  - State is IDLE.
  - `x`, `busy`, `done`, `pass`, `err`, `err_count`, `mismatch_map` and `first_err_idx` are all 0.
- Reset mid-sweep aborts the sweep and all results are lost. The first active edge after `rst_n` rises is in IDLE.
- If `start` is sampled high at edge k, the next edge at which it takes effect:
  - `busy` = 1 and `x` = 0 after edge k.
  - Vector i is sampled at edge k + (i+1)·SETTLE, and `x` shows i+1 after that edge for i < 7.
  - `err` for vector i is high during the cycle after edge k + (i+1)·SETTLE.
  - After edge k + 8·SETTLE: `busy` = 0 and `done` = 1.
  - For SETTLE = 2, `done` rises after edge k + 16.
- Each vector is stable at the logic input for exactly SETTLE cycles before it is sampled.
- `err_count`, `mismatch_map` and `first_err_idx` update on the same edge as the `err` strobe.
- A `start` held high continuously causes back-to-back sweeps. `done` is high for exactly one cycle between them.

## Test plan
- **Matching parity.** TRUTH_TABLE = 8'b1001_0110, SETTLE = 2, `z` driven as `^x`, start pulsed at edge 0 → `x` steps 0..7 every 2 cycles; `done` = 1 after edge 16; `pass` = 1; `err_count` = 0; `mismatch_map` = 8'h00; `err` never asserted.
- **Two faulty vectors.** Same table, but the model inverts `z` for x = 3 and x = 6 → `err` pulses twice; `err_count` = 2; `mismatch_map` = 8'b0100_1000; `first_err_idx` = 3; `pass` = 0.
- **Unknown output.** SETTLE = 1, TRUTH_TABLE = 8'hFF, `z` = 1 except `z` = X for x = 0 → `done` after edge 8; `err_count` = 1; `first_err_idx` = 0; `mismatch_map` = 8'h01.
- **Reset mid-sweep.** Assert `rst_n` = 0 asynchronously, between edges, while x = 4 → all outputs go to 0 immediately without waiting for a clock. After release, a start produces a full clean sweep from x = 0.
- **Ignored start and restart.** Pulse `start` while `busy` → no effect on `x` or on timing. Pulse `start` in DONE after a failing sweep → `done` drops next edge; counts clear; a passing model gives `pass` = 1.
- **Continuous start.** `start` held high for 3 sweeps with SETTLE = 3 → `done` is high for one cycle at edges 24, 49 and 74 (one-cycle DONE between sweeps); `x` returns to 0 each time.
